// File: rtl/video_linedouble.sv
// Purpose: scandoubler; each 15 kHz input line is written to a ping-pong RAM bank and replayed twice at 2x pixel rate.
// Latency: output pixel x of both copies is input pixel x of the previous completed line, one line plus 2 clk.
// Backpressure: none; free-running read side, input sampled on ce_pix. Optional 50% scanline on copy 1 via VIDEO_SCANLINES_EN.
module video_linedouble #(
    parameter int ADDR_W   = 9,
    parameter int HS_WIDTH = 12,
    parameter int MIN_LEN  = 16,
    parameter int RST_LEN  = 341
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       HSync,
    input  logic       VSync,
    input  logic       HBlank,
    input  logic       VBlank,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    output logic       ce_pix2,
    output logic       HSync2,
    output logic       VSync2,
    output logic       HBlank2,
    output logic       VBlank2,
    output logic [7:0] R2,
    output logic [7:0] G2,
    output logic [7:0] B2,
    output logic       line_rep
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE       = 1;
    localparam logic [ADDR_W:0] MIN_LEN_V = MIN_LEN[ADDR_W:0];
    localparam logic [ADDR_W:0] RST_LEN_V = RST_LEN[ADDR_W:0];
    localparam logic [ADDR_W:0] HS_W_V    = HS_WIDTH[ADDR_W:0];

    // Two banks of {HBlank, R, G, B}; bank select is the address MSB.
    logic [24:0] mem [0:2*DEPTH-1];
    logic [24:0] rd_dat_q;

    // Write-side state
    logic              hs_prev_q, hs_prev_d;
    logic [ADDR_W:0]   in_x_q, in_x_d;
    logic              bank_q, bank_d;
    logic [ADDR_W:0]   out_len_q, out_len_d;
    logic              vs_l_q, vs_l_d, vb_l_q, vb_l_d;
    logic              seen_q, seen_d;
    logic              valid_q, valid_d;

    // Read-side state
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] out_x_q, out_x_d;
    logic              rep_q, rep_d;
    logic [ADDR_W:0]   out_x_nx;

    // Pipeline stage aligned with the RAM read data
    logic p1_vld_q, p1_hs_q, p1_vs_q, p1_vb_q, p1_rep_q, p1_valid_q;

    logic        bnd;
    logic        wr_en;
    logic [23:0] pix_rgb;

    assign bnd      = ce_pix & HSync & ~hs_prev_q;
    assign wr_en    = ce_pix & ~bnd & ~in_x_q[ADDR_W];
    assign out_x_nx = {1'b0, out_x_q} + ONE;

    // Write side: line-length measurement, bank flip and frame-sync latching on each HSync rise.
    always_comb begin
        hs_prev_d = hs_prev_q;
        in_x_d    = in_x_q;
        bank_d    = bank_q;
        out_len_d = out_len_q;
        vs_l_d    = vs_l_q;
        vb_l_d    = vb_l_q;
        seen_d    = seen_q;
        valid_d   = valid_q;
        if (ce_pix) begin
            hs_prev_d = HSync;
            if (bnd) begin
                in_x_d = '0;
                bank_d = ~bank_q;
                vs_l_d = VSync;
                vb_l_d = VBlank;
                seen_d = 1'b1;
                // The first boundary after reset closes a partial line; picture starts one boundary later.
                if (seen_q) valid_d = 1'b1;
                // in_x saturates at the bank depth, so the capture is already clamped.
                if (in_x_q >= MIN_LEN_V) out_len_d = in_x_q;
            end else if (!in_x_q[ADDR_W]) begin
                in_x_d = in_x_q + ONE;
            end
        end
    end

    // Read side: slot every other clk; a boundary restarts the line pair and realigns the slot phase.
    always_comb begin
        phase_d = bnd ? 1'b0 : ~phase_q;
        out_x_d = out_x_q;
        rep_d   = rep_q;
        if (bnd) begin
            out_x_d = '0;
            rep_d   = 1'b0;
        end else if (phase_q) begin
            if (out_x_nx >= out_len_q) begin
                out_x_d = '0;
                rep_d   = 1'b1;
            end else begin
                out_x_d = out_x_nx[ADDR_W-1:0];
            end
        end
    end

    // State registers for both sides.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_q <= 1'b0;
            in_x_q    <= '0;
            bank_q    <= 1'b0;
            out_len_q <= RST_LEN_V;
            vs_l_q    <= 1'b0;
            vb_l_q    <= 1'b0;
            seen_q    <= 1'b0;
            valid_q   <= 1'b0;
            phase_q   <= 1'b0;
            out_x_q   <= '0;
            rep_q     <= 1'b0;
        end else begin
            hs_prev_q <= hs_prev_d;
            in_x_q    <= in_x_d;
            bank_q    <= bank_d;
            out_len_q <= out_len_d;
            vs_l_q    <= vs_l_d;
            vb_l_q    <= vb_l_d;
            seen_q    <= seen_d;
            valid_q   <= valid_d;
            phase_q   <= phase_d;
            out_x_q   <= out_x_d;
            rep_q     <= rep_d;
        end
    end

    // Line buffer: write into the active bank, read the opposite bank (pre-toggle on a boundary cycle).
    always_ff @(posedge clk) begin
        if (wr_en) mem[{bank_q, in_x_q[ADDR_W-1:0]}] <= {HBlank, R, G, B};
        rd_dat_q <= mem[{~bank_q, out_x_q}];
    end

    // Carry slot control alongside the RAM read so syncs line up with the pixel data.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_vld_q   <= 1'b0;
            p1_hs_q    <= 1'b0;
            p1_vs_q    <= 1'b0;
            p1_vb_q    <= 1'b0;
            p1_rep_q   <= 1'b0;
            p1_valid_q <= 1'b0;
        end else begin
            p1_vld_q   <= phase_q;
            p1_hs_q    <= ({1'b0, out_x_q} < HS_W_V);
            p1_vs_q    <= vs_l_q;
            p1_vb_q    <= vb_l_q;
            p1_rep_q   <= rep_q;
            p1_valid_q <= valid_q;
        end
    end

    // Second copy optionally dimmed to half brightness.
    always_comb begin
        pix_rgb = rd_dat_q[23:0];
`ifdef VIDEO_SCANLINES_EN
        if (p1_rep_q) begin
            pix_rgb = {1'b0, rd_dat_q[23:17], 1'b0, rd_dat_q[15:9], 1'b0, rd_dat_q[7:1]};
        end
`endif
    end

    // Output registers; updated only on pixel pulses, blanked until a full line is buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_pix2  <= 1'b0;
            HSync2   <= 1'b0;
            VSync2   <= 1'b0;
            HBlank2  <= 1'b0;
            VBlank2  <= 1'b0;
            R2       <= '0;
            G2       <= '0;
            B2       <= '0;
            line_rep <= 1'b0;
        end else begin
            ce_pix2 <= p1_vld_q;
            if (p1_vld_q) begin
                HSync2   <= p1_hs_q;
                VSync2   <= p1_vs_q;
                VBlank2  <= p1_vb_q;
                line_rep <= p1_rep_q;
                HBlank2  <= p1_valid_q ? rd_dat_q[24] : 1'b1;
                {R2, G2, B2} <= p1_valid_q ? pix_rgb : 24'h0;
            end
        end
    end

endmodule

// File: tb/tb_video_linedouble.sv
module tb_video_linedouble;

    logic       clk = 1'b0;
    logic       reset, ce_pix, HSync, VSync, HBlank, VBlank;
    logic [7:0] R, G, B;
    logic       ce_pix2, HSync2, VSync2, HBlank2, VBlank2, line_rep;
    logic [7:0] R2, G2, B2;

    video_linedouble dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .R(R), .G(G), .B(B),
        .ce_pix2(ce_pix2), .HSync2(HSync2), .VSync2(VSync2),
        .HBlank2(HBlank2), .VBlank2(VBlank2),
        .R2(R2), .G2(G2), .B2(B2), .line_rep(line_rep)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int seg = 0;
    logic tb_hs_prev = 1'b0;

    // Per-segment statistics of output pulses; a segment is the span between two input boundaries.
    int cnt [16], n0 [16], n1 [16], nvs [16], nvb [16], nhs [16], npic [16];
    logic [24:0] cap0 [16][512];
    logic [24:0] cap1 [16][512];
    int sh1 = 0, sh2 = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            cnt[i] = 0; n0[i] = 0; n1[i] = 0; nvs[i] = 0; nvb[i] = 0; nhs[i] = 0; npic[i] = 0;
        end
    end

    // A pulse seen now belongs to the segment that was current two clocks earlier (the read slot).
    always @(negedge clk) begin
        if (ce_pix2 === 1'b1) begin
            cnt[sh2]++;
            if (line_rep === 1'b0) begin
                if (n0[sh2] < 512) cap0[sh2][n0[sh2]] = {HBlank2, R2, G2, B2};
                n0[sh2]++;
            end else begin
                if (n1[sh2] < 512) cap1[sh2][n1[sh2]] = {HBlank2, R2, G2, B2};
                n1[sh2]++;
            end
            if (VSync2 === 1'b1) nvs[sh2]++;
            if (VBlank2 === 1'b1) nvb[sh2]++;
            if (HSync2 === 1'b1) nhs[sh2]++;
            if (HBlank2 !== 1'b1 || {R2, G2, B2} !== 24'h0) npic[sh2]++;
        end
        sh2 = sh1;
        sh1 = seg;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] f(input int ln, input int x);
        logic [7:0] x8, l8;
        x8 = x[7:0];
        l8 = ln[7:0];
        return {x8, 8'h54 ^ l8, ~x8};
    endfunction

    function automatic logic [24:0] ex(input int ln, input int x);
        return {(x >= 256), f(ln, x)};
    endfunction

    function automatic logic [24:0] sc(input logic [24:0] v);
`ifdef VIDEO_SCANLINES_EN
        return {v[24], 1'b0, v[23:17], 1'b0, v[15:9], 1'b0, v[7:1]};
`else
        return v;
`endif
    endfunction

    // One ce_pix sample followed by three idle clocks; called and returns at posedge+1.
    task automatic pix(input logic hs, input logic vs, input logic hb, input logic [23:0] rgb);
        ce_pix = 1'b1; HSync = hs; VSync = vs; VBlank = vs; HBlank = hb;
        {R, G, B} = rgb;
        @(posedge clk); #1;
        ce_pix = 1'b0;
        if (hs && !tb_hs_prev) seg++;
        tb_hs_prev = hs;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Samples s0..s1 of line ln; sample 0 is the HSync rise, sample s carries pixel x = s-1.
    task automatic line(input int ln, input logic vs0, input logic vsr, input int s0, input int s1, input logic hs_en);
        for (int s = s0; s <= s1; s++) begin
            pix(hs_en && (s < 25), (s == 0) ? vs0 : vsr, (s - 1) >= 256, f(ln, s - 1));
        end
    endtask

    initial begin
        int bad;
        reset = 1'b1; ce_pix = 1'b0; HSync = 1'b0; VSync = 1'b0;
        HBlank = 1'b0; VBlank = 1'b0; R = 8'h0; G = 8'h0; B = 8'h0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_outputs", {ce_pix2, HSync2, VSync2, HBlank2, VBlank2, R2, G2, B2, line_rep}, 64'h0);
        reset = 1'b0;

        line(0, 1'b0, 1'b0, 1, 10, 1'b0);      // short partial line before the first boundary
        line(1, 1'b0, 1'b0, 0, 340, 1'b1);
        line(2, 1'b0, 1'b0, 0, 340, 1'b1);
        line(3, 1'b0, 1'b1, 0, 340, 1'b1);     // VSync rises on the sample after B3
        line(4, 1'b1, 1'b1, 0, 340, 1'b1);
        line(5, 1'b1, 1'b1, 0, 340, 1'b1);
        line(6, 1'b1, 1'b0, 0, 340, 1'b1);
        line(7, 1'b0, 1'b0, 0, 2, 1'b1);       // HSync drops for 5 samples then re-rises: glitch
        line(7, 1'b0, 1'b0, 3, 7, 1'b0);
        line(8, 1'b0, 1'b0, 0, 340, 1'b1);
        line(9, 1'b0, 1'b0, 0, 100, 1'b1);     // reset lands at x=100

        reset = 1'b1; seg = 10; tb_hs_prev = 1'b0;
        @(posedge clk); #1;
        chk("midline_reset_outputs", {ce_pix2, HSync2, VSync2, HBlank2, VBlank2, R2, G2, B2, line_rep}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_blank", {HBlank2, R2, G2, B2}, {1'b1, 24'h0});

        line(10, 1'b0, 1'b0, 101, 300, 1'b0);
        line(11, 1'b0, 1'b0, 0, 340, 1'b1);
        line(12, 1'b0, 1'b0, 0, 340, 1'b1);
        line(13, 1'b0, 1'b0, 0, 0, 1'b1);
        repeat (8) @(posedge clk);
        #1;

        // Segment 1: reset line length 341 per copy, still blanked
        chk("seg1_pulses", cnt[1], 682);
        chk("seg1_copy0", n0[1], 341);
        chk("seg1_copy1", n1[1], 341);
        chk("seg1_blank", npic[1], 0);
        chk("seg1_hsync", nhs[1], 24);

        // Segment 2: measured length 340, replaying line 1
        chk("seg2_pulses", cnt[2], 682);
        chk("seg2_copy0", n0[2], 340);
        chk("seg2_copy1", n1[2], 342);
        chk("seg2_hsync", nhs[2], 26);
        chk("seg2_x0", cap0[2][0], 25'h00055FF);
        chk("seg2_x255", cap0[2][255], 25'h0FF5500);
        chk("seg2_x256", cap0[2][256], 25'h10055FF);
        chk("seg2_x339", cap0[2][339], 25'h15355AC);
        bad = 0;
        for (int x = 0; x < 340; x++) begin
            if (cap0[2][x] !== ex(1, x)) bad++;
            if (cap1[2][x] !== sc(ex(1, x))) bad++;
        end
        chk("seg2_both_copies", bad, 0);

        // VSync latched at B4..B6 -> six output lines
        for (int s = 3; s <= 7; s++) begin
            chk($sformatf("seg%0d_vsync", s), nvs[s], (s >= 4 && s <= 6) ? 682 : 0);
            chk($sformatf("seg%0d_vblank", s), nvb[s], (s >= 4 && s <= 6) ? 682 : 0);
        end

        // Glitch: segment 7 is cut short, length stays 340 afterwards, out_x restarts
        chk("seg7_pulses", cnt[7], 16);
        chk("seg7_copy0", n0[7], 16);
        chk("seg8_pulses", cnt[8], 682);
        chk("seg8_copy0", n0[8], 340);
        chk("seg8_hsync", nhs[8], 26);
        chk("seg8_x0", cap0[8][0], ex(7, 0));
        chk("seg8_x6", cap0[8][6], ex(7, 6));
        chk("seg9_x100", cap0[9][100], ex(8, 100));

        // After mid-line reset: RST_LEN again, blank until the second boundary
        chk("seg10_copy0", n0[10], 341);
        chk("seg10_blank", npic[10], 0);
        chk("seg10_hsync", nhs[10], 24);
        chk("seg11_copy0", n0[11], 200);
        chk("seg11_copy1", n1[11], 482);
        chk("seg11_blank", npic[11], 0);
        chk("seg12_picture", npic[12] > 0, 1);
        chk("seg12_x0", cap0[12][0], ex(11, 0));
        chk("seg12_x300", cap0[12][300], ex(11, 300));
        chk("seg12_rep_x300", cap1[12][300], sc(ex(11, 300)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
